// File: rtl/frog_pixel_gen.sv
// Frogger game logic and pixel colour stage upstream of vga_driver.
// Colour is registered one clock after next_x/next_y.
module frog_pixel_gen #(
    parameter int GRID      = 40,
    parameter int START_COL = 7,
    parameter int START_ROW = 11,
    parameter int LIVES     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [7:0] color_out,
    output logic [3:0] frog_col,
    output logic [3:0] frog_row,
    output logic [1:0] lives,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] btn;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;
    logic [3:0] rise;
    logic [3:0] pend;
    logic [9:0] car_x [4];
    logic       chk;
    logic       tick;
    logic       hit;
    logic       on_car;
    logic       road;
    logic [7:0] pix;
    logic [9:0] cell_x;
    logic [9:0] cell_y;
    logic [10:0] frog_px;

    assign game_state = state;
    assign btn  = {btn_right, btn_left, btn_down, btn_up};
    assign rise = sync2 & ~prev;
    assign tick = (next_x == 10'd0) && (next_y == 10'd480);

    assign cell_x  = next_x / 10'(GRID);
    assign cell_y  = next_y / 10'(GRID);
    assign frog_px = 11'(frog_col) * 11'(GRID);

    function automatic logic [3:0] lane_row(input int k);
        return 4'(9 - 2 * k);
    endfunction

    // Even lanes drift right, odd lanes left; speed is lane index + 1.
    function automatic logic [9:0] car_step(
        input logic [9:0] x,
        input int         k
    );
        logic [10:0] s;
        logic [10:0] w;
        s = 11'(k + 1);
        if (k % 2 == 0) begin
            w = {1'b0, x} + s;
            if (w >= 11'd640) w = w - 11'd640;
        end else if ({1'b0, x} < s) begin
            w = {1'b0, x} + 11'd640 - s;
        end else begin
            w = {1'b0, x} - s;
        end
        return w[9:0];
    endfunction

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (frog_row == lane_row(k)
                && {1'b0, car_x[k]} < frog_px + 11'(GRID)
                && frog_px < {1'b0, car_x[k]} + 11'(2 * GRID))
                hit = 1'b1;
        end
    end

    always_comb begin
        on_car = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (cell_y == 10'(lane_row(k))
                && next_x >= car_x[k]
                && {1'b0, next_x} < {1'b0, car_x[k]} + 11'(2 * GRID))
                on_car = 1'b1;
        end
        road = (cell_y == 10'd3) || (cell_y == 10'd5)
            || (cell_y == 10'd7) || (cell_y == 10'd9);
        if (next_x >= 10'd640 || next_y >= 10'd480)
            pix = 8'h00;
        else if (state == OVER)
            pix = 8'hE0;
        else if (state == WIN)
            pix = 8'h1C;
        else if (cell_x == 10'(frog_col) && cell_y == 10'(frog_row))
            pix = 8'hFC;
        else if (on_car)
            pix = 8'hE0;
        else if (cell_y == 10'd0)
            pix = 8'h03;
        else if (road)
            pix = 8'h49;
        else
            pix = 8'h10;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_out <= 8'h00;
            sync1     <= 4'd0;
            sync2     <= 4'd0;
            prev      <= 4'd0;
            pend      <= 4'd0;
            chk       <= 1'b0;
            state     <= PLAY;
            frog_col  <= 4'(START_COL);
            frog_row  <= 4'(START_ROW);
            lives     <= 2'(LIVES);
            for (int k = 0; k < 4; k++) car_x[k] <= 10'(k * 160);
        end else begin
            color_out <= pix;
            sync1     <= btn;
            sync2     <= sync1;
            prev      <= sync2;
            chk       <= tick && (state == PLAY);
            pend      <= tick ? rise : (pend | rise);

            // Checks run the cycle after cars and frog have moved.
            if (chk && state == PLAY) begin
                if (hit) begin
                    if (lives > 2'd1) begin
                        lives    <= lives - 2'd1;
                        frog_col <= 4'(START_COL);
                        frog_row <= 4'(START_ROW);
                    end else begin
                        lives <= 2'd0;
                        state <= OVER;
                    end
                end else if (frog_row == 4'd0) begin
                    state <= WIN;
                end
            end

            if (tick) begin
                if (state == PLAY) begin
                    if (pend[0]) begin
                        if (frog_row != 4'd0) frog_row <= frog_row - 4'd1;
                    end else if (pend[1]) begin
                        if (frog_row != 4'd11) frog_row <= frog_row + 4'd1;
                    end else if (pend[2]) begin
                        if (frog_col != 4'd0) frog_col <= frog_col - 4'd1;
                    end else if (pend[3]) begin
                        if (frog_col != 4'd15) frog_col <= frog_col + 4'd1;
                    end
                    for (int k = 0; k < 4; k++)
                        car_x[k] <= car_step(car_x[k], k);
                end else if (|pend) begin
                    sync1    <= 4'd0;
                    sync2    <= 4'd0;
                    prev     <= 4'd0;
                    pend     <= 4'd0;
                    state    <= PLAY;
                    frog_col <= 4'(START_COL);
                    frog_row <= 4'(START_ROW);
                    lives    <= 2'(LIVES);
                    for (int k = 0; k < 4; k++) car_x[k] <= 10'(k * 160);
                end
            end
        end
    end

endmodule

// File: doc/frog_pixel_gen.md
Name: frog_pixel_gen

Overview:
- Game-logic and pixel-colour stage that sits directly upstream of vga_driver in the frogger top level.
- Consumes vga_driver's next_x/next_y scan coordinates and the player buttons.
- Maintains frog position, four moving cars, lives and game state.
- Produces the registered RRRGGGBB color_in byte for each pixel.

Parameters:
- GRID, 40, cell size in pixels; the playfield is 16 columns x 12 rows of 640x480.
- START_COL, 7, frog spawn column.
- START_ROW, 11, frog spawn row (bottom row).
- LIVES, 3, lives at game start (1..3).

Ports:
- clock  input  1  25 MHz pixel clock (same clock as vga_driver).
- reset  input  1  asynchronous, active-high; clears all state.
- btn_up  input  1  asynchronous level, active-high.
- btn_down  input  1  asynchronous level, active-high.
- btn_left  input  1  asynchronous level, active-high.
- btn_right  input  1  asynchronous level, active-high.
- next_x  input  10  x of the next pixel, from vga_driver.
- next_y  input  10  y of the next pixel, from vga_driver.
- color_out  output  8  RRRGGGBB pixel colour, to vga_driver color_in.
- frog_col  output  4  current frog column.
- frog_row  output  4  current frog row.
- lives  output  2  remaining lives.
- game_state  output  2  PLAY=0, WIN=1, OVER=2.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - color_out=0.
  - frog_col=START_COL, frog_row=START_ROW.
  - lives=LIVES, game_state=PLAY.
  - car_x[k]=k*160 for k=0..3.
  - Pending move and synchronizers cleared.
- Button input:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets a sticky pending flag for that direction.
  - All pending flags clear on each frame tick.
- Frame tick: single-cycle pulse when next_x==0 and next_y==480 (once per frame, at the start of vertical blank).
- Tick cycle T, state PLAY:
  - Apply at most one pending move, priority up > down > left > right.
  - up decrements row, down increments row, left decrements col, right increments col.
  - Moves clamp at the bounds: row 0..11, col 0..15. A move into a wall is discarded.
- Tick cycle T, cars (in the same cycle, PLAY only):
  - Lane 0: row 9, moves right 1 px/frame.
  - Lane 1: row 7, moves left 2 px/frame.
  - Lane 2: row 5, moves right 3 px/frame.
  - Lane 3: row 3, moves left 4 px/frame.
  - Wrap right: if car_x+s>=640, car_x becomes car_x+s-640.
  - Wrap left: if car_x<s, car_x becomes car_x+640-s.
  - car_x is always in 0..639.
- Cycle T+1, checks (PLAY only):
  - Collision: frog_row equals the lane row AND car_x < frog_col*GRID+GRID AND frog_col*GRID < car_x+2*GRID (11-bit compare, no wrap).
  - On collision with lives>1: lives decrements and the frog returns to spawn.
  - On collision with lives==1: lives=0 and game_state becomes OVER.
  - Win: if frog_row==0, game_state becomes WIN. Collision and win cannot coincide because row 0 has no lane.
- WIN and OVER states:
  - Frog and cars freeze.
  - The first frame tick with any pending flag restarts the game: all reset values except color_out, game_state=PLAY.
- Pixel colour (registered, latency exactly 1 clock from next_x/next_y; cell = next_x/GRID, next_y/GRID):
  - Black 8'h00 if next_x>=640 or next_y>=480.
  - Else OVER: red 8'hE0 everywhere.
  - Else WIN: green 8'h1C everywhere.
  - Else frog cell: yellow 8'hFC.
  - Else car pixel: red 8'hE0. A car pixel satisfies car_x <= next_x < car_x+2*GRID in the car's row. The car is clipped at x=639; the wrapped part is not drawn.
  - Else row 0 (goal): blue 8'h03.
  - Else rows 3, 5, 7, 9 (road): grey 8'h49.
  - Else grass: 8'h10.
- Reset mid-frame: outputs return to reset values immediately. The next frame tick behaves normally.
- Simultaneous events:
  - Button edge in the tick cycle itself: counts for the following tick.
  - Multiple directions pending: only the highest priority applies and all pending flags clear.

Test Plan:
- Reset, then drive next_x=300, next_y=460 (frog cell 7,11) -> color_out=8'hFC one clock later. next_x=700 -> 8'h00.
- Pulse btn_up for 3 cycles, then run to the frame tick -> frog_row=10 after T. Hold btn_up continuously for 5 frames -> still one move only (edge-based).
- Frog at col 0, press left -> frog_col stays 0. Press up and right before one tick -> only row decrements.
- Lane 1 car_x=1; after one tick car_x=639. Lane 3 car_x=3; after one tick car_x=639. Lane 0 car_x=639; after one tick car_x=0.
- Place frog in row 9 at col 2 with lane-0 car_x=60 -> at T+1 lives 3->2 and frog at (7,11). Repeat until lives=1, then collide -> game_state=OVER, every visible pixel 8'hE0.
- Step frog up 11 times avoiding cars -> game_state=WIN, pixels 8'h1C. Press any button -> PLAY, lives=LIVES, car_x=0/160/320/480. Assert reset mid-line -> color_out=0 asynchronously.
